// File: rtl/vga_line_plotter_if.sv
// Line-plotter configuration port: valid/ready write channel plus pending flag.
// The master writes line settings; the slave (plotter) accepts and reports pending state.
interface vga_line_plotter_if #(
    parameter int CW  = 3,
    parameter int SLW = 4,
    parameter int OFW = 11,
    parameter int CHW = 2
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic           cfg_en;
    logic [SLW-1:0] cfg_slope;
    logic [OFW-1:0] cfg_offset;
    logic [CW-1:0]  cfg_color;
    logic           cfg_pending;

    modport master (
        output cfg_valid, cfg_ch, cfg_en, cfg_slope, cfg_offset, cfg_color,
        input  cfg_ready, cfg_pending
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_en, cfg_slope, cfg_offset, cfg_color,
        output cfg_ready, cfg_pending
    );
endinterface

// File: rtl/vga_line_plotter.sv
// N_CH-channel y = slope*x + offset overlay; config is shadowed and committed at frame start.
// Optional macro PLOTTER_AXES_EN draws the x/y axes in all-ones where no line hits.
module vga_line_plotter #(
    parameter int XW   = 10,
    parameter int CW   = 3,
    parameter int N_CH = 4,
    parameter int SLW  = 4,
    parameter int OFW  = 11,
    parameter int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_i,
    input  logic [XW-1:0]     counter_x_i,
    input  logic [XW-1:0]     counter_y_i,
    input  logic              in_display_i,
    vga_line_plotter_if.slave cfg,
    output logic [CW-1:0]     pixel_o,
    output logic [CHW-1:0]    hit_ch_o,
    output logic              hit_o
);
    localparam int TW = XW + SLW + OFW + 1;

    logic [N_CH-1:0]       sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic signed [SLW-1:0] sh_sl_q [N_CH], sh_sl_d [N_CH];
    logic signed [SLW-1:0] act_sl_q [N_CH], act_sl_d [N_CH];
    logic signed [OFW-1:0] sh_of_q [N_CH], sh_of_d [N_CH];
    logic signed [OFW-1:0] act_of_q [N_CH], act_of_d [N_CH];
    logic [CW-1:0]         sh_col_q [N_CH], sh_col_d [N_CH];
    logic [CW-1:0]         act_col_q [N_CH], act_col_d [N_CH];
    logic                  pend_q, pend_d;

    logic [N_CH-1:0]       s1_match_q, s1_match_d;
    logic [CW-1:0]         s1_col_q [N_CH];
    logic                  s1_disp_q, s1_axis_q, s1_axis_d;

    logic [CW-1:0]         pix_q, pix_d;
    logic                  hit_q, hit_d;
    logic [CHW-1:0]        hch_q, hch_d;

    logic signed [TW-1:0]  xs, ys;
    logic signed [TW-1:0]  t_w [N_CH];
    logic                  wr;
    logic                  found;

    // Writes are refused on the commit cycle so they can never race the bank copy.
    assign cfg.cfg_ready   = ~frame_start_i;
    assign cfg.cfg_pending = pend_q;
    assign wr              = cfg.cfg_valid & ~frame_start_i;

    assign xs = TW'(counter_x_i);
    assign ys = TW'(counter_y_i);

`ifdef PLOTTER_AXES_EN
    assign s1_axis_d = (counter_x_i == '0) | (counter_y_i == '0);
`else
    assign s1_axis_d = 1'b0;
`endif

    // Shadow-bank writes and frame-start commit into the active bank.
    always_comb begin
        sh_en_d   = sh_en_q;
        sh_sl_d   = sh_sl_q;
        sh_of_d   = sh_of_q;
        sh_col_d  = sh_col_q;
        act_en_d  = act_en_q;
        act_sl_d  = act_sl_q;
        act_of_d  = act_of_q;
        act_col_d = act_col_q;
        pend_d    = pend_q;
        if (wr) begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg.cfg_ch == CHW'(i)) begin
                    sh_en_d[i]  = cfg.cfg_en;
                    sh_sl_d[i]  = signed'(cfg.cfg_slope);
                    sh_of_d[i]  = signed'(cfg.cfg_offset);
                    sh_col_d[i] = cfg.cfg_color;
                    pend_d      = 1'b1;
                end
            end
        end
        if (frame_start_i && pend_q) begin
            act_en_d  = sh_en_q;
            act_sl_d  = sh_sl_q;
            act_of_d  = sh_of_q;
            act_col_d = sh_col_q;
            pend_d    = 1'b0;
        end
    end

    // Stage 1: exact signed line evaluation per channel, no truncation.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            t_w[i]        = TW'(act_sl_q[i]) * xs + TW'(act_of_q[i]);
            s1_match_d[i] = act_en_q[i] && (t_w[i] == ys);
        end
    end

    // Stage 2: lowest-index match wins; axes fill only non-hit pixels.
    always_comb begin
        pix_d = '0;
        hit_d = 1'b0;
        hch_d = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (s1_disp_q && s1_match_q[i] && !found) begin
                found = 1'b1;
                pix_d = s1_col_q[i];
                hit_d = 1'b1;
                hch_d = CHW'(i);
            end
        end
        if (!found && s1_disp_q && s1_axis_q) pix_d = '1;
    end

    // Config banks and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_en_q  <= '0;
            act_en_q <= '0;
            pend_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                sh_sl_q[i]   <= '0;
                sh_of_q[i]   <= '0;
                sh_col_q[i]  <= '0;
                act_sl_q[i]  <= '0;
                act_of_q[i]  <= '0;
                act_col_q[i] <= '0;
            end
        end else begin
            sh_en_q   <= sh_en_d;
            sh_sl_q   <= sh_sl_d;
            sh_of_q   <= sh_of_d;
            sh_col_q  <= sh_col_d;
            act_en_q  <= act_en_d;
            act_sl_q  <= act_sl_d;
            act_of_q  <= act_of_d;
            act_col_q <= act_col_d;
            pend_q    <= pend_d;
        end
    end

    // Pipeline registers; colours travel with the match so a commit cannot split a pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_match_q <= '0;
            s1_disp_q  <= 1'b0;
            s1_axis_q  <= 1'b0;
            pix_q      <= '0;
            hit_q      <= 1'b0;
            hch_q      <= '0;
            for (int i = 0; i < N_CH; i++) s1_col_q[i] <= '0;
        end else begin
            s1_match_q <= s1_match_d;
            s1_disp_q  <= in_display_i;
            s1_axis_q  <= s1_axis_d;
            s1_col_q   <= act_col_q;
            pix_q      <= pix_d;
            hit_q      <= hit_d;
            hch_q      <= hch_d;
        end
    end

    assign pixel_o  = pix_q;
    assign hit_o    = hit_q;
    assign hit_ch_o = hch_q;
endmodule
